// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - EX operand forwarding selects and load-use stall for the 5-stage core
// Optional stall counter enabled by defining FWD_PERF_CNT_EN.
module fwd_hazard_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      flush,
    output logic [1:0]                fwd_a_sel,
    output logic [1:0]                fwd_b_sel,
    output logic                      stall,
    output logic [DATA_WIDTH-1:0]     stall_count
);

    logic                      ex_valid;
    logic [REG_ADDR_WIDTH-1:0] ex_rs1;
    logic [REG_ADDR_WIDTH-1:0] ex_rs2;
    logic [REG_ADDR_WIDTH-1:0] ex_rd;
    logic                      ex_reg_write;
    logic                      ex_mem_read;

    logic                      mem_valid;
    logic [REG_ADDR_WIDTH-1:0] mem_rd;
    logic                      mem_reg_write;

    logic                      wb_valid;
    logic [REG_ADDR_WIDTH-1:0] wb_rd;
    logic                      wb_reg_write;

    logic                      mem_writer;
    logic                      wb_writer;
    logic                      ex_load_hit;
    logic                      issue;

    assign mem_writer = mem_valid && mem_reg_write && (mem_rd != '0);
    assign wb_writer  = wb_valid && wb_reg_write && (wb_rd != '0);

    // Only the hazard on rs fields matters; id_rd / id_reg_write are deliberately ignored.
    assign ex_load_hit = ex_valid && ex_mem_read && (ex_rd != '0) &&
                         ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    assign stall = id_valid && !flush && ex_load_hit;
    assign issue = id_valid && !flush && !stall;

    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (ex_valid) begin
            if (mem_writer && (mem_rd == ex_rs1)) begin
                fwd_a_sel = 2'b01;
            end else if (wb_writer && (wb_rd == ex_rs1)) begin
                fwd_a_sel = 2'b10;
            end
            if (mem_writer && (mem_rd == ex_rs2)) begin
                fwd_b_sel = 2'b01;
            end else if (wb_writer && (wb_rd == ex_rs2)) begin
                fwd_b_sel = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_rd         <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            mem_valid     <= 1'b0;
            mem_rd        <= '0;
            mem_reg_write <= 1'b0;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_reg_write  <= 1'b0;
        end else begin
            wb_valid      <= mem_valid;
            wb_rd         <= mem_rd;
            wb_reg_write  <= mem_reg_write;
            mem_valid     <= ex_valid;
            mem_rd        <= ex_rd;
            mem_reg_write <= ex_reg_write;
            ex_valid      <= issue;
            ex_rs1        <= id_rs1;
            ex_rs2        <= id_rs2;
            ex_rd         <= id_rd;
            ex_reg_write  <= id_reg_write;
            ex_mem_read   <= id_mem_read;
        end
    end

`ifdef FWD_PERF_CNT_EN
    logic [DATA_WIDTH-1:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - randomized self-checking bench for fwd_hazard_ctrl
module tb_fwd_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        flush;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic        stall;
    logic [31:0] stall_count;

    fwd_hazard_ctrl #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall        (stall),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } ent_t;

    // Instruction history by age: index 0 = EX, 1 = MEM, 2 = WB.
    ent_t        pipe[$];
    int unsigned model_stalls;
    logic        last_stall;
    int          tests;
    int          fails;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Youngest older instruction that writes the operand wins; x0 is never a producer.
    function automatic logic [1:0] exp_sel(input logic [4:0] rs);
        if (!pipe[0].v) return 2'b00;
        for (int a = 1; a <= 2; a++) begin
            if (pipe[a].v && pipe[a].rw && pipe[a].rd != 5'd0 && pipe[a].rd == rs)
                return a[1:0];
        end
        return 2'b00;
    endfunction

    function automatic logic exp_stall();
        return id_valid && !flush && pipe[0].v && pipe[0].mr && pipe[0].rd != 5'd0 &&
               (pipe[0].rd == id_rs1 || pipe[0].rd == id_rs2);
    endfunction

    task automatic model_clear();
        pipe.delete();
        for (int i = 0; i < 3; i++) pipe.push_back('0);
        model_stalls = 0;
        last_stall   = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
        id_valid     = v;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
        flush        = fl;
        #1;
    endtask

    task automatic tick();
        logic es;
        ent_t ne;
        @(negedge clk);
        es = exp_stall();
        check_eq("stall", {31'd0, stall}, {31'd0, es});
        check_eq("fwd_a", {30'd0, fwd_a_sel}, {30'd0, exp_sel(pipe[0].rs1)});
        check_eq("fwd_b", {30'd0, fwd_b_sel}, {30'd0, exp_sel(pipe[0].rs2)});
`ifdef FWD_PERF_CNT_EN
        check_eq("stall_count", stall_count, model_stalls);
`else
        check_eq("stall_count", stall_count, 32'd0);
`endif
        last_stall = es;
        @(posedge clk);
        if (id_valid && !flush && !es)
            ne = {1'b1, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read};
        else
            ne = '0;
        pipe.push_front(ne);
        void'(pipe.pop_back());
        if (es) model_stalls++;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_fwd_a", {30'd0, fwd_a_sel}, 32'd0);
        check_eq("rst_fwd_b", {30'd0, fwd_b_sel}, 32'd0);
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_count", stall_count, 32'd0);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        do_reset();

        // back-to-back ALU dependency
        drive(1, 5'd0, 5'd0, 5'd5, 1, 0, 0); tick();
        drive(1, 5'd5, 5'd1, 5'd6, 1, 0, 0); tick();
        check_eq("b2b_a", {30'd0, fwd_a_sel}, 32'd1);
        check_eq("b2b_b", {30'd0, fwd_b_sel}, 32'd0);
        check_eq("b2b_stall", {31'd0, stall}, 32'd0);

        // distance-2 dependency on rs2
        drive(1, 5'd0, 5'd0, 5'd7, 1, 0, 0); tick();
        drive(1, 5'd1, 5'd2, 5'd9, 1, 0, 0); tick();
        drive(1, 5'd3, 5'd7, 5'd10, 1, 0, 0); tick();
        check_eq("d2_b", {30'd0, fwd_b_sel}, 32'd2);
        check_eq("d2_a", {30'd0, fwd_a_sel}, 32'd0);

        // two producers of x5: MEM wins
        drive(1, 5'd0, 5'd0, 5'd5, 1, 0, 0); tick();
        drive(1, 5'd0, 5'd0, 5'd5, 1, 0, 0); tick();
        drive(1, 5'd5, 5'd0, 5'd11, 1, 0, 0); tick();
        check_eq("prio_a", {30'd0, fwd_a_sel}, 32'd1);

        // load-use: one stall cycle, then WB forward
        drive(1, 5'd0, 5'd0, 5'd8, 1, 1, 0); tick();
        drive(1, 5'd8, 5'd1, 5'd12, 1, 0, 0);
        check_eq("lu_stall", {31'd0, stall}, 32'd1);
        tick();
        check_eq("lu_bubble_stall", {31'd0, stall}, 32'd0);
        tick();
        check_eq("lu_fwd_a", {30'd0, fwd_a_sel}, 32'd2);

        // load into x0 never stalls or forwards
        drive(1, 5'd0, 5'd0, 5'd0, 1, 1, 0); tick();
        drive(1, 5'd0, 5'd0, 5'd13, 1, 0, 0);
        check_eq("x0_stall", {31'd0, stall}, 32'd0);
        tick();
        check_eq("x0_fwd_a", {30'd0, fwd_a_sel}, 32'd0);

        // flush overrides a load-use hazard
        drive(1, 5'd0, 5'd0, 5'd9, 1, 1, 0); tick();
        drive(1, 5'd9, 5'd0, 5'd14, 1, 0, 1);
        check_eq("flush_stall", {31'd0, stall}, 32'd0);
        tick();

        // three load-use stalls from a clean reset
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, 5'd0, 5'd0, 5'd10, 1, 1, 0); tick();
            drive(1, 5'd2, 5'd10, 5'd15, 1, 0, 0); tick();
            tick();
        end
`ifdef FWD_PERF_CNT_EN
        check_eq("cnt3", stall_count, 32'd3);
`else
        check_eq("cnt_off", stall_count, 32'd0);
`endif

        // randomized traffic; ID is held while the model says it stalled
        for (int i = 0; i < 3000; i++) begin
            if (i == 1000 || i == 2200) do_reset();
            if (!last_stall) begin
                drive(($urandom_range(0, 9) != 0),
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
            end else begin
                flush = ($urandom_range(0, 9) == 0);
                #1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
